// File: rtl/smg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : smg_pkg
//  Description : Shared constants for the 2-digit 7-segment display scheduler:
//                active-low segment codes, digit-select codes and the state
//                encodings of the arbiter and scan state machines.
//  Revision    : 1.0 - initial release
// ============================================================================
package smg_pkg;

    // Active-low segment patterns, decimal point (bit 7) off
    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // AND mask that lights the decimal point (active-low dp on bit 7)
    localparam logic [7:0] DP_MASK   = 8'h7F;

    // Active-low digit selects
    localparam logic [1:0] CS_ONES   = 2'b10;
    localparam logic [1:0] CS_TENS   = 2'b01;
    localparam logic [1:0] CS_OFF    = 2'b11;

    // Arbiter states
    localparam logic [0:0] A_IDLE    = 1'b0;
    localparam logic [0:0] A_OWN     = 1'b1;

    // Scan states
    localparam logic [2:0] S_OFF     = 3'd0;
    localparam logic [2:0] S_D0      = 3'd1;
    localparam logic [2:0] S_B0      = 3'd2;
    localparam logic [2:0] S_D1      = 3'd3;
    localparam logic [2:0] S_B1      = 3'd4;

endpackage
`default_nettype wire

// File: rtl/smg_seg_decode.sv
`default_nettype none
// ============================================================================
//  Module      : smg_seg_decode
//  Description : Combinational nibble to active-low 7-segment decoder
//                (0-9, A, b, C, d, E, F), decimal point off.
//  Revision    : 1.0 - initial release
// ============================================================================
module smg_seg_decode (
    input  logic [3:0] nibble,
    output logic [7:0] seg
);
    import smg_pkg::*;

    // Hex digit lookup
    always_comb begin
        seg = SEG_BLANK;
        case (nibble)
            4'h0: seg = SEG_0;
            4'h1: seg = SEG_1;
            4'h2: seg = SEG_2;
            4'h3: seg = SEG_3;
            4'h4: seg = SEG_4;
            4'h5: seg = SEG_5;
            4'h6: seg = SEG_6;
            4'h7: seg = SEG_7;
            4'h8: seg = SEG_8;
            4'h9: seg = SEG_9;
            4'hA: seg = SEG_A;
            4'hB: seg = SEG_B;
            4'hC: seg = SEG_C;
            4'hD: seg = SEG_D;
            4'hE: seg = SEG_E;
            4'hF: seg = SEG_F;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/smg_disp_sched.sv
`default_nettype none
// ============================================================================
//  Module      : smg_disp_sched
//  Description : Ownership arbiter and scan controller for a shared 2-digit
//                common-anode 7-segment display. Two requesters compete for
//                the display with a minimum hold time per owner; the digits
//                are time-multiplexed with blanking gaps between slots.
//                Build option SMG_HEX_MODE_EN: show the value as two hex
//                digits instead of decimal ones/tens (no overflow dp).
//  Revision    : 1.0 - initial release
// ============================================================================
module smg_disp_sched #(
    parameter int SCAN_CYC  = 50_000,
    parameter int BLANK_CYC = 250,
    parameter int HOLD_CYC  = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    output logic [1:0] gnt,
    output logic       owner,
    output logic [1:0] cs,
    output logic [7:0] dx
);
    import smg_pkg::*;

    localparam int HOLD_W   = $clog2(HOLD_CYC + 1);
    localparam int SLOT_MAX = (SCAN_CYC > BLANK_CYC) ? SCAN_CYC : BLANK_CYC;
    localparam int SLOT_W   = $clog2(SLOT_MAX + 1);

    localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYC - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);
    localparam logic [SLOT_W-1:0] SCAN_LAST  = SLOT_W'(SCAN_CYC - 1);
    localparam logic [SLOT_W-1:0] BLANK_LAST = SLOT_W'(BLANK_CYC - 1);
    localparam logic [SLOT_W-1:0] SLOT_ONE   = SLOT_W'(1);

    // ------------------------------------------------------------------
    // Arbiter
    // ------------------------------------------------------------------
    logic [0:0]        r_arb_state;
    logic [0:0]        w_arb_next;
    logic [1:0]        r_gnt;
    logic              r_owner;
    logic [7:0]        r_value;
    logic [HOLD_W-1:0] r_hold_cnt;
    logic [HOLD_W-1:0] w_hold_inc;
    logic              r_expired;

    logic [1:0]        w_req_eff;
    logic              w_own_req;
    logic              w_oth_req;
    logic              w_take;
    logic              w_take_idx;
    logic              w_restart;

    // A request still high during its own grant cycle is the tail of the
    // request just served, not a new one.
    assign w_req_eff  = req & ~r_gnt;
    assign w_own_req  = w_req_eff[r_owner];
    assign w_oth_req  = w_req_eff[~r_owner];
    assign w_hold_inc = r_hold_cnt + HOLD_ONE;

    // Arbiter state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_arb_state <= A_IDLE;
        else        r_arb_state <= w_arb_next;
    end

    // Arbiter next state: ownership, once taken, is never released
    always_comb begin
        w_arb_next = r_arb_state;
        case (r_arb_state)
            A_IDLE:  if (|w_req_eff) w_arb_next = A_OWN;
            A_OWN:   w_arb_next = A_OWN;
            default: w_arb_next = A_IDLE;
        endcase
    end

    // Arbiter decisions: who is granted this cycle and whether the hold restarts
    always_comb begin
        w_take     = 1'b0;
        w_take_idx = 1'b0;
        w_restart  = 1'b0;
        case (r_arb_state)
            A_IDLE: begin
                if (|w_req_eff) begin
                    w_take     = 1'b1;
                    w_take_idx = w_req_eff[0] ? 1'b0 : 1'b1;
                    w_restart  = 1'b1;
                end
            end
            A_OWN: begin
                // An expired hold lets the other side in even if the owner
                // is also asking; the owner's request simply stays pending.
                if (r_expired && w_oth_req) begin
                    w_take     = 1'b1;
                    w_take_idx = ~r_owner;
                    w_restart  = 1'b1;
                end else if (w_own_req) begin
                    w_take     = 1'b1;
                    w_take_idx = r_owner;
                end
            end
            default: ;
        endcase
    end

    // Grant pulse, value latch, owner and hold timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt      <= 2'b00;
            r_owner    <= 1'b0;
            r_value    <= 8'h00;
            r_hold_cnt <= '0;
            r_expired  <= 1'b0;
        end else begin
            r_gnt <= 2'b00;
            if (w_take) begin
                r_gnt   <= w_take_idx ? 2'b10 : 2'b01;
                r_owner <= w_take_idx;
                r_value <= w_take_idx ? req_data1 : req_data0;
            end
            // Owner updates do not restart the hold; only a change of owner does
            if (w_restart) begin
                r_hold_cnt <= '0;
                r_expired  <= (HOLD_CYC <= 1);
            end else if (r_arb_state == A_OWN && r_hold_cnt != HOLD_LAST) begin
                r_hold_cnt <= w_hold_inc;
                if (w_hold_inc == HOLD_LAST) r_expired <= 1'b1;
            end
        end
    end

    assign gnt   = r_gnt;
    assign owner = r_owner;

    // ------------------------------------------------------------------
    // Digit extraction and decode
    // ------------------------------------------------------------------
    logic [3:0] w_ones_nib;
    logic [3:0] w_tens_nib;
    logic       w_ovf;
    logic [7:0] w_ones_seg;
    logic [7:0] w_tens_seg;
    logic [7:0] w_ones_pat;
    logic [7:0] w_tens_pat;

`ifdef SMG_HEX_MODE_EN
    assign w_ones_nib = r_value[3:0];
    assign w_tens_nib = r_value[7:4];
    assign w_ovf      = 1'b0;
`else
    assign w_ones_nib = 4'(r_value % 8'd10);
    assign w_tens_nib = 4'((r_value / 8'd10) % 8'd10);
    assign w_ovf      = (r_value > 8'd99);
`endif

    smg_seg_decode u_dec_ones (
        .nibble (w_ones_nib),
        .seg    (w_ones_seg)
    );

    smg_seg_decode u_dec_tens (
        .nibble (w_tens_nib),
        .seg    (w_tens_seg)
    );

    // Ones dp flags a value that does not fit two decimal digits; tens dp marks owner 1
    assign w_ones_pat = w_ones_seg & (w_ovf   ? DP_MASK : SEG_BLANK);
    assign w_tens_pat = w_tens_seg & (r_owner ? DP_MASK : SEG_BLANK);

    // ------------------------------------------------------------------
    // Scan controller
    // ------------------------------------------------------------------
    logic [2:0]        r_scan_state;
    logic [2:0]        w_scan_next;
    logic [SLOT_W-1:0] r_slot_cnt;
    logic              w_slot_done;
    logic [1:0]        r_cs;
    logic [7:0]        r_dx;
    logic [1:0]        w_cs_nxt;
    logic [7:0]        w_dx_nxt;

    // End-of-slot detect for the current scan state
    always_comb begin
        w_slot_done = 1'b0;
        case (r_scan_state)
            S_D0, S_D1: w_slot_done = (r_slot_cnt == SCAN_LAST);
            S_B0, S_B1: w_slot_done = (r_slot_cnt == BLANK_LAST);
            default:    w_slot_done = 1'b0;
        endcase
    end

    // Scan state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_scan_state <= S_OFF;
        else        r_scan_state <= w_scan_next;
    end

    // Scan next state: stay dark until something has been granted, then loop
    always_comb begin
        w_scan_next = r_scan_state;
        case (r_scan_state)
            S_OFF:   if (r_arb_state == A_OWN) w_scan_next = S_D0;
            S_D0:    if (w_slot_done) w_scan_next = S_B0;
            S_B0:    if (w_slot_done) w_scan_next = S_D1;
            S_D1:    if (w_slot_done) w_scan_next = S_B1;
            S_B1:    if (w_slot_done) w_scan_next = S_D0;
            default: w_scan_next = S_OFF;
        endcase
    end

    // Scan outputs: patterns are captured only on slot entry so a new value
    // never alters a digit part-way through its slot.
    always_comb begin
        w_cs_nxt = r_cs;
        w_dx_nxt = r_dx;
        if (w_scan_next != r_scan_state) begin
            case (w_scan_next)
                S_D0: begin
                    w_cs_nxt = CS_ONES;
                    w_dx_nxt = w_ones_pat;
                end
                S_D1: begin
                    w_cs_nxt = CS_TENS;
                    w_dx_nxt = w_tens_pat;
                end
                default: begin
                    w_cs_nxt = CS_OFF;
                    w_dx_nxt = SEG_BLANK;
                end
            endcase
        end
    end

    // Slot timer and registered display pins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_cnt <= '0;
            r_cs       <= CS_OFF;
            r_dx       <= SEG_BLANK;
        end else begin
            if (w_scan_next != r_scan_state)
                r_slot_cnt <= '0;
            else if (r_scan_state != S_OFF)
                r_slot_cnt <= r_slot_cnt + SLOT_ONE;
            r_cs <= w_cs_nxt;
            r_dx <= w_dx_nxt;
        end
    end

    assign cs = r_cs;
    assign dx = r_dx;

endmodule
`default_nettype wire

// File: tb/tb_smg_disp_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_smg_disp_sched
//  Description : Self-checking bench for smg_disp_sched with short timings.
//                Expected grants and expected scan slots are queued when the
//                stimulus is applied and compared as the DUT produces them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_smg_disp_sched;

    localparam int SCAN_CYC  = 8;
    localparam int BLANK_CYC = 2;
    localparam int HOLD_CYC  = 40;

`ifdef SMG_HEX_MODE_EN
    localparam logic [7:0] T1_ONES  = 8'h90, T1_TENS  = 8'hB0;  // 0x39
    localparam logic [7:0] T2_ONES  = 8'h88, T2_TENS  = 8'h24;  // 0x2A, owner 1
    localparam logic [7:0] T3_ONES  = 8'h83, T3_TENS  = 8'hF8;  // 0x7B
    localparam logic [7:0] T4U_ONES = 8'h80, T4U_TENS = 8'h92;  // 0x58
    localparam logic [7:0] T4S_ONES = 8'hA1, T4S_TENS = 8'h19;  // 0x4D, owner 1
`else
    localparam logic [7:0] T1_ONES  = 8'hF8, T1_TENS  = 8'h92;  // 57
    localparam logic [7:0] T2_ONES  = 8'hA4, T2_TENS  = 8'h19;  // 42, owner 1
    localparam logic [7:0] T3_ONES  = 8'h30, T3_TENS  = 8'hA4;  // 123, overflow dp
    localparam logic [7:0] T4U_ONES = 8'h80, T4U_TENS = 8'h80;  // 88
    localparam logic [7:0] T4S_ONES = 8'hF8, T4S_TENS = 8'h78;  // 77, owner 1
`endif

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       req0      = 1'b0;
    logic       req1      = 1'b0;
    logic [7:0] req_data0 = 8'h00;
    logic [7:0] req_data1 = 8'h00;
    logic [1:0] gnt;
    logic       owner;
    logic [1:0] cs;
    logic [7:0] dx;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    typedef struct {
        logic [1:0] cs;
        logic [7:0] dx;
        int         len;
    } slot_t;

    slot_t      slot_q[$];
    logic [1:0] gnt_q[$];
    logic [1:0] exp_gnt;

    smg_disp_sched #(
        .SCAN_CYC  (SCAN_CYC),
        .BLANK_CYC (BLANK_CYC),
        .HOLD_CYC  (HOLD_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       ({req1, req0}),
        .req_data0 (req_data0),
        .req_data1 (req_data1),
        .gnt       (gnt),
        .owner     (owner),
        .cs        (cs),
        .dx        (dx)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Every grant pulse must match the next expected grant in order
    always @(negedge clk) begin
        if (rst_n && gnt != 2'b00) begin
            if (gnt_q.size() == 0) begin
                chk("gnt_unexpected", {30'd0, gnt}, 32'd0);
            end else begin
                exp_gnt = gnt_q.pop_front();
                chk("gnt_order", {30'd0, gnt}, {30'd0, exp_gnt});
            end
        end
    end

    task automatic apply_reset();
        req0  = 1'b0;
        req1  = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Raise a request, wait for its grant, drop it; report latency and grant cycle
    task automatic do_req(input int idx, input logic [7:0] data, output int lat, output int gcyc);
        int start;
        bit seen;
        seen = 1'b0;
        if (idx == 0) begin req_data0 = data; req0 = 1'b1; end
        else          begin req_data1 = data; req1 = 1'b1; end
        start = cyc;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            if (gnt[idx]) seen = 1'b1;
        end
        chk($sformatf("gnt%0d_seen", idx), {31'd0, seen}, 32'd1);
        lat  = cyc - start;
        gcyc = cyc;
        if (idx == 0) req0 = 1'b0;
        else          req1 = 1'b0;
    endtask

    // Queue nslots expected slots from the next ones-digit entry, then compare runs
    task automatic check_scan(input string tag, input logic [7:0] ones_dx,
                              input logic [7:0] tens_dx, input int nslots,
                              output int wait_cyc);
        slot_t      s;
        logic [9:0] cur;
        logic [1:0] prev_cs;
        int         len;
        int         budget;
        bit         found;
        for (int i = 0; i < nslots; i++) begin
            case (i % 4)
                0:       s = '{2'b10, ones_dx, SCAN_CYC};
                2:       s = '{2'b01, tens_dx, SCAN_CYC};
                default: s = '{2'b11, 8'hFF, BLANK_CYC};
            endcase
            slot_q.push_back(s);
        end
        found    = 1'b0;
        wait_cyc = 0;
        prev_cs  = cs;
        while (!found && wait_cyc < 100) begin
            @(negedge clk);
            wait_cyc++;
            if (cs == 2'b10 && prev_cs != 2'b10) found = 1'b1;
            prev_cs = cs;
        end
        chk({tag, "_start"}, {31'd0, found}, 32'd1);
        cur    = {cs, dx};
        len    = 1;
        budget = 0;
        while (found && slot_q.size() > 0 && budget < 500) begin
            @(negedge clk);
            budget++;
            if ({cs, dx} == cur) begin
                len++;
            end else begin
                s = slot_q.pop_front();
                chk({tag, "_cs_dx"}, {22'd0, cur}, {22'd0, s.cs, s.dx});
                chk({tag, "_len"}, len, s.len);
                cur = {cs, dx};
                len = 1;
            end
        end
        chk({tag, "_slots_left"}, slot_q.size(), 0);
        slot_q.delete();
    endtask

    initial begin
        #400us;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, lat1, latu, g0, g1, gu, w, bad;
        bit found;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_cs",    {30'd0, cs},    32'h3);
        chk("rst_dx",    {24'd0, dx},    32'hFF);
        chk("rst_gnt",   {30'd0, gnt},   32'h0);
        chk("rst_owner", {31'd0, owner}, 32'h0);
        rst_n = 1'b1;

        // Idle: dark, no grants
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (cs !== 2'b11 || dx !== 8'hFF || gnt !== 2'b00) bad++;
        end
        chk("idle_dark", bad, 0);

        // Single request, then scan pattern
        gnt_q.push_back(2'b01);
        do_req(0, 8'd57, lat, g0);
        chk("t1_gnt_lat", lat, 1);
        chk("t1_owner", {31'd0, owner}, 32'd0);
        check_scan("t1", T1_ONES, T1_TENS, 8, w);
        chk("t1_scan_lat", w, 1);

        // Simultaneous requests: 0 first, 1 after the hold expires
        apply_reset();
        gnt_q.push_back(2'b01);
        gnt_q.push_back(2'b10);
        fork
            do_req(0, 8'd1, lat, g0);
            do_req(1, 8'd42, lat1, g1);
        join
        chk("t2_gnt0_lat", lat, 1);
        chk("t2_hold", g1 - g0, HOLD_CYC);
        chk("t2_owner", {31'd0, owner}, 32'd1);
        check_scan("t2", T2_ONES, T2_TENS, 4, w);

        // Overflow indicator
        apply_reset();
        gnt_q.push_back(2'b01);
        do_req(0, 8'd123, lat, g0);
        check_scan("t3", T3_ONES, T3_TENS, 4, w);

        // Owner update during hold does not restart it
        apply_reset();
        gnt_q.push_back(2'b01);
        do_req(0, 8'd10, lat, g0);
        gnt_q.push_back(2'b01);
        gnt_q.push_back(2'b10);
        fork
            do_req(1, 8'd77, lat1, g1);
            begin
                repeat (19) @(negedge clk);
                do_req(0, 8'd88, latu, gu);
                check_scan("t4u", T4U_ONES, T4U_TENS, 4, w);
            end
        join
        chk("t4_upd_lat", latu, 1);
        chk("t4_upd_at", gu - g0, 20);
        chk("t4_hold", g1 - g0, HOLD_CYC);
        chk("t4_owner", {31'd0, owner}, 32'd1);
        check_scan("t4s", T4S_ONES, T4S_TENS, 4, w);

        // Asynchronous reset in the middle of the tens slot
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (cs == 2'b01) found = 1'b1;
        end
        chk("t5_in_d1", {31'd0, found}, 32'd1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_cs",    {30'd0, cs},    32'h3);
        chk("t5_dx",    {24'd0, dx},    32'hFF);
        chk("t5_gnt",   {30'd0, gnt},   32'h0);
        chk("t5_owner", {31'd0, owner}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (cs !== 2'b11 || dx !== 8'hFF || gnt !== 2'b00) bad++;
        end
        chk("t5_dark_after", bad, 0);

`ifdef SMG_HEX_MODE_EN
        // Hex letters
        apply_reset();
        gnt_q.push_back(2'b01);
        do_req(0, 8'hAB, lat, g0);
        check_scan("hex", 8'h83, 8'h88, 4, w);
`endif

        chk("gnt_q_empty", gnt_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
